// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, register map constants and FSM state
// types for the register file.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int         NUM_RW_REGS = 6;
    localparam logic [2:0] REG_WCOUNT  = 3'd6;
    localparam logic [2:0] REG_ID      = 3'd7;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave with six RW registers, a write-commit counter and an ID
// register; the write and read channels run as independent FSMs.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA1B2_0001
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [RESP_WIDTH-1:0]     s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [RESP_WIDTH-1:0]     s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [DATA_WIDTH-1:0]     ctrl_o
);

    localparam int NB = DATA_WIDTH / 8;

    wr_state_t r_wstate;
    wr_state_t w_wstate_next;
    rd_state_t r_rstate;
    rd_state_t w_rstate_next;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic [RESP_WIDTH-1:0] r_bresp;
    logic [RESP_WIDTH-1:0] r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_wcount;

    logic [NUM_RW_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [NUM_RW_REGS-1:0][DATA_WIDTH-1:0] w_regs_next;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;

    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NB-1:0]         w_wr_strb;
    logic [2:0]            w_wr_idx;
    logic                  w_wr_oor;
    logic                  w_wr_ok;

    logic [2:0]            w_rd_idx;
    logic                  w_rd_oor;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic                  w_unused_lsbs;

    // Readies depend only on state so the handshakes never loop back through
    // the next-state logic; reset masks them while it is held.
    assign w_awready = ~s_axi_areset & ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_DATA));
    assign w_wready  = ~s_axi_areset & ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_ADDR));
    assign w_arready = ~s_axi_areset & (r_rstate == R_IDLE);

    assign w_aw_hs = s_axi_awvalid & w_awready;
    assign w_w_hs  = s_axi_wvalid  & w_wready;
    assign w_ar_hs = s_axi_arvalid & w_arready;

    // ---------------------------------------------------------------- write
    always_comb begin
        w_wstate_next = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_next = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    w_wstate_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: if (w_w_hs)       w_wstate_next = W_RESP;
            W_HAVE_DATA: if (w_aw_hs)      w_wstate_next = W_RESP;
            W_RESP:      if (s_axi_bready) w_wstate_next = W_IDLE;
            default:                       w_wstate_next = W_IDLE;
        endcase
    end

    // The edge that completes the AW/W pair is the commit edge; the half
    // arriving on that edge is taken straight from the bus.
    assign w_commit  = (r_wstate != W_RESP) && (w_wstate_next == W_RESP);
    assign w_wr_addr = w_aw_hs ? s_axi_awaddr : r_awaddr;
    assign w_wr_data = w_w_hs  ? s_axi_wdata  : r_wdata;
    assign w_wr_strb = w_w_hs  ? s_axi_wstrb  : r_wstrb;
    assign w_wr_idx  = w_wr_addr[4:2];
    assign w_wr_oor  = (w_wr_addr >> 5) != '0;
    assign w_wr_ok   = !w_wr_oor && (w_wr_idx < 3'(NUM_RW_REGS));

    genvar gi, gb;
    generate
        for (gi = 0; gi < NUM_RW_REGS; gi++) begin : g_reg
            for (gb = 0; gb < NB; gb++) begin : g_byte
                assign w_regs_next[gi][gb*8 +: 8] =
                    (w_commit && w_wr_ok && (w_wr_idx == 3'(gi)) && w_wr_strb[gb])
                        ? w_wr_data[gb*8 +: 8]
                        : r_regs[gi][gb*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= '0;
            r_regs   <= '0;
            r_wcount <= '0;
        end else begin
            r_wstate <= w_wstate_next;
            r_regs   <= w_regs_next;
            if (w_aw_hs) begin
                r_awaddr <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_wr_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
                if (w_wr_ok) begin
                    r_wcount <= r_wcount + DATA_WIDTH'(1);
                end
            end
        end
    end

    // ----------------------------------------------------------------- read
    assign w_rd_idx = s_axi_araddr[4:2];
    assign w_rd_oor = (s_axi_araddr >> 5) != '0;

    always_comb begin
        w_rd_data = '0;
        if (!w_rd_oor) begin
            if (w_rd_idx == REG_WCOUNT) begin
                w_rd_data = r_wcount;
            end else if (w_rd_idx == REG_ID) begin
                w_rd_data = ID_VALUE;
            end else begin
                w_rd_data = r_regs[w_rd_idx];
            end
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs)      w_rstate_next = R_DATA;
            R_DATA:  if (s_axi_rready) w_rstate_next = R_IDLE;
            default:                   w_rstate_next = R_IDLE;
        endcase
    end

    // Read data samples the pre-edge registers, so a write committing on the
    // same edge is not visible to this read.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_oor ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_arready = w_arready;
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign ctrl_o        = r_regs[0];

    // Byte-lane address bits carry no meaning for word registers.
    assign w_unused_lsbs = ^{w_wr_addr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed scenarios plus a randomized
// write/read mix compared against a word-level register map model.
module tb_axi_lite_regfile;

    localparam logic [31:0] ID = 32'hA1B2_0001;
    localparam int          TMO = 60;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] ctrl;

    int checks = 0;
    int failures = 0;

    // Reference model: six plain words, a commit count and the ID.
    logic [31:0] m_regs [6];
    logic [31:0] m_cnt;

    axi_lite_regfile dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (areset),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .ctrl_o       (ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic bit is_rw(input logic [7:0] a);
        return (a < 8'd32) && (a / 4 < 6);
    endfunction

    function automatic logic [1:0] exp_wresp(input logic [7:0] a);
        return is_rw(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [7:0] a);
        if (a >= 8'd32) return 32'h0;
        if (a / 4 == 6) return m_cnt;
        if (a / 4 == 7) return ID;
        return m_regs[a / 4];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [7:0] a);
        return (a >= 8'd32) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (is_rw(a)) begin
            m_regs[a / 4] = merge(m_regs[a / 4], d, s);
            m_cnt = m_cnt + 1;
        end
    endtask

    // Bus drivers: issue AW/W with optional per-channel delays, then take B.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        int n;
        bit aw_done, w_done, aw_fire, w_fire;
        awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
        n = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && n < TMO) begin
            awvalid = !aw_done && (n >= aw_dly);
            wvalid  = !w_done && (n >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick(); n++;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) begin
            failures++;
            $display("FAIL write_timeout addr=%h got no bvalid required bvalid=1", a);
        end
        resp = bresp;
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bit fired;
        araddr = a; arvalid = 1'b1; n = 0; fired = 0;
        while (!fired && n < TMO) begin fired = arready; tick(); n++; end
        arvalid = 1'b0;
        while (!rvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) begin
            failures++;
            $display("FAIL read_timeout addr=%h got no rvalid required rvalid=1", a);
        end
        data = rdata; resp = rresp;
        rready = 1'b1; tick(); rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        areset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshakes got=%b required=00000", {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({bresp, rresp, rdata, ctrl} !== 68'h0) begin
            failures++;
            $display("FAIL reset_data got bresp=%h rresp=%h rdata=%h ctrl=%h required all 0", bresp, rresp, rdata, ctrl);
        end
        areset = 1'b0;
        model_reset();
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=111", {awready, wready, arready});
        end
        axi_read(8'h1C, d, r);
        checks++;
        if (d !== ID || r !== 2'b00) begin
            failures++;
            $display("FAIL reset_id got=%h/%b required=%h/00", d, r, ID);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        logic [1:0]  r;
        awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(8'h04, 32'hDEADBEEF, 4'hF);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_b got bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                     bvalid, bresp, awready, wready);
        end
        bready = 1'b1; tick(); bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_bdone got bvalid=%b awready=%b required 0 1", bvalid, awready);
        end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== exp_rdata(8'h04) || r !== 2'b00) begin
            failures++;
            $display("FAIL same_cycle_read got=%h/%b required=%h/00", d, r, exp_rdata(8'h04));
        end
        axi_read(8'h18, d, r);
        checks++;
        if (d !== m_cnt) begin
            failures++;
            $display("FAIL same_cycle_count got=%h required=%h", d, m_cnt);
        end
    endtask

    task automatic test_w_then_aw();
        logic [1:0] r;
        axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
        model_write(8'h00, 32'hFFFF_FFFF, 4'hF);
        wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0) begin
            failures++;
            $display("FAIL w_first_ready got awready=%b wready=%b required 1 0", awready, wready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bvalid !== 1'b0) begin
                failures++;
                $display("FAIL w_first_early_b cycle=%0d got bvalid=%b required 0", i, bvalid);
            end
            if (i < 2) tick();
        end
        awaddr = 8'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        model_write(8'h00, 32'h1234_5678, 4'b0011);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || ctrl !== m_regs[0]) begin
            failures++;
            $display("FAIL w_first_commit got bvalid=%b bresp=%b ctrl=%h required 1 00 %h",
                     bvalid, bresp, ctrl, m_regs[0]);
        end
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h1C, 32'h5555_AAAA, 4'hF, 1, 0, r);
        checks++;
        if (r !== exp_wresp(8'h1C)) begin
            failures++;
            $display("FAIL slverr_wr_id got=%b required=%b", r, exp_wresp(8'h1C));
        end
        axi_write(8'h18, 32'h0000_0100, 4'hF, 0, 1, r);
        checks++;
        if (r !== 2'b10) begin
            failures++;
            $display("FAIL slverr_wr_count got=%b required=10", r);
        end
        axi_read(8'h1C, d, r);
        checks++;
        if (d !== ID || r !== 2'b00) begin
            failures++;
            $display("FAIL slverr_rd_id got=%h/%b required=%h/00", d, r, ID);
        end
        axi_read(8'h40, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            failures++;
            $display("FAIL slverr_rd_oor got=%h/%b required=0/10", d, r);
        end
        axi_read(8'h18, d, r);
        checks++;
        if (d !== m_cnt) begin
            failures++;
            $display("FAIL slverr_count got=%h required=%h", d, m_cnt);
        end
    endtask

    task automatic test_bready_stall();
        logic [31:0] v, d;
        logic [1:0]  r;
        v = $urandom;
        awaddr = 8'h08; wdata = v; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(8'h08, v, 4'hF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d got bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                         i, bvalid, bresp, awready, wready);
            end
            tick();
        end
        bready = 1'b1; tick(); bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got bvalid=%b awready=%b wready=%b required 0 1 1", bvalid, awready, wready);
        end
        axi_read(8'h08, d, r);
        checks++;
        if (d !== m_regs[2]) begin
            failures++;
            $display("FAIL stall_readback got=%h required=%h", d, m_regs[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        awaddr = 8'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            failures++;
            $display("FAIL mid_have_addr got awready=%b wready=%b required 0 1", awready, wready);
        end
        areset = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b0 || ctrl !== 32'h0) begin
            failures++;
            $display("FAIL mid_in_reset got bvalid=%b ctrl=%h required 0 0", bvalid, ctrl);
        end
        areset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_reset got awready=%b bvalid=%b required 1 0", awready, bvalid);
        end
        axi_read(8'h18, d, r);
        checks++;
        if (d !== m_cnt) begin
            failures++;
            $display("FAIL mid_count got=%h required=%h", d, m_cnt);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h08, 32'h11, 4'hF, 0, 0, r);
        model_write(8'h08, 32'h11, 4'hF);
        awaddr = 8'h08; wdata = 32'h22; wstrb = 4'hF; araddr = 8'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        d = exp_rdata(8'h08);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(8'h08, 32'h22, 4'hF);
        checks++;
        if (rvalid !== 1'b1 || rdata !== d || bvalid !== 1'b1) begin
            failures++;
            $display("FAIL collide_old got rvalid=%b rdata=%h bvalid=%b required 1 %h 1", rvalid, rdata, bvalid, d);
        end
        rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
        axi_read(8'h08, d, r);
        checks++;
        if (d !== m_regs[2]) begin
            failures++;
            $display("FAIL collide_new got=%h required=%h", d, m_regs[2]);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [31:0] v, d;
        logic [3:0]  s;
        logic [1:0]  r;
        for (int i = 0; i < 80; i++) begin
            a = 8'($urandom_range(0, 47));
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                s = 4'($urandom);
                axi_write(a, v, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
                checks++;
                if (r !== exp_wresp(a)) begin
                    failures++;
                    $display("FAIL rand_wr[%0d] addr=%h got resp=%b required=%b", i, a, r, exp_wresp(a));
                end
                model_write(a, v, s);
                checks++;
                if (ctrl !== m_regs[0]) begin
                    failures++;
                    $display("FAIL rand_ctrl[%0d] got=%h required=%h", i, ctrl, m_regs[0]);
                end
            end else begin
                axi_read(a, d, r);
                checks++;
                if (d !== exp_rdata(a) || r !== exp_rresp(a)) begin
                    failures++;
                    $display("FAIL rand_rd[%0d] addr=%h got=%h/%b required=%h/%b",
                             i, a, d, r, exp_rdata(a), exp_rresp(a));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_same_cycle();
        test_w_then_aw();
        test_slverr();
        test_bready_stall();
        test_collision();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
